// File: rtl/pulse_stretcher_pkg.sv
// Purpose: shared clock constant and time-to-count helpers for pulse stretcher / sampler.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pulse_stretcher_pkg;

    // Board system clock (CLK_125MHZ_FPGA).
    localparam int CLOCK_FREQ = 125_000_000;

    // Number of clk cycles in the given number of microseconds.
    function automatic int us_to_cycles(input int us);
        return (CLOCK_FREQ / 1_000_000) * us;
    endfunction

    // Number of sample ticks of tick_us microseconds that fit in ms milliseconds.
    function automatic int ms_to_ticks(input int ms, input int tick_us);
        return (ms * 1000) / tick_us;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Purpose: free-running prescaler emitting a 1-cycle tick every CNT_MAX clocks.
// Latency: first tick CNT_MAX-1 edges after reset release, then every CNT_MAX cycles.
// Backpressure: none; free-running.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the prescaler
//   tick - 1-cycle strobe, high while the prescaler sits at CNT_MAX-1
module sample_tick_gen
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // Keep at least one bit so CNT_MAX=1 (tick every cycle) still elaborates.
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

    logic [CW-1:0] sample_cnt;

    assign tick = (sample_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Purpose: stretch single-cycle event pulses per channel so LEDs stay visibly lit.
// Latency: out[i] rises on the first edge after in[i] is sampled high; registered output.
// Backpressure: none; every pulse is accepted, a pulse during a hold simply reloads it.
//
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, clears prescaler and all hold counters
//   in  - WIDTH event pulses, one bit per channel (may be held high)
//   out - WIDTH stretched outputs, high while the channel hold counter is non-zero
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = us_to_cycles(500),
    parameter int PULSE_CNT_MAX  = ms_to_ticks(100, 500)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam int HW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(PULSE_CNT_MAX);

    logic tick;

    sample_tick_gen #(
        .CNT_MAX (SAMPLE_CNT_MAX)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [HW-1:0] cnt;

        // A pulse always wins over the tick so a retrigger never loses a count;
        // the non-zero gate keeps an idle channel parked at zero.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (in[i]) begin
                cnt <= HOLD_LOAD;
            end else if (tick && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end

        // Decoded from the counter register only: no combinational in->out path.
        assign out[i] = (cnt != '0);
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout;

    int vectors    = 0;
    int miscompares = 0;
    int ph         = 0;   // prescaler phase expected after the most recent edge

    pulse_stretcher #(
        .WIDTH          (4),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive rst/in 1 time unit after an edge, let the next edge sample them,
    // then compare out 1 time unit after that edge.
    task automatic step(input logic r, input logic [3:0] in_v,
                        input logic [3:0] exp, input string tag);
        rst = r;
        din = in_v;
        @(posedge clk);
        #1;
        ph = r ? 0 : (ph + 1) % 4;
        vectors++;
        assert (dout === exp) else begin
            miscompares++;
            $error("FAIL %s: out=%b expected %b (phase %0d)", tag, dout, exp, ph);
        end
    endtask

    task automatic chk_tick(input logic exp, input string tag);
        vectors++;
        assert (dut.u_tick.tick === exp) else begin
            miscompares++;
            $error("FAIL %s: tick=%b expected %b", tag, dut.u_tick.tick, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 4'b0000;

        // 1: reset for 2 cycles, inputs active must be ignored.
        step(1'b1, 4'b1111, 4'b0000, "reset_c1");
        step(1'b1, 4'b1111, 4'b0000, "reset_c2");
        step(1'b0, 4'b0000, 4'b0000, "post_rst_1");
        chk_tick(1'b0, "tick_ph1");
        step(1'b0, 4'b0000, 4'b0000, "post_rst_2");
        chk_tick(1'b0, "tick_ph2");
        step(1'b0, 4'b0000, 4'b0000, "post_rst_3");
        chk_tick(1'b1, "tick_ph3");

        // 2: pulse sampled on the tick edge -> held exactly 12 cycles.
        step(1'b0, 4'b0001, 4'b0001, "basic_rise");
        for (int k = 0; k < 11; k++) step(1'b0, 4'b0000, 4'b0001, "basic_hold");
        step(1'b0, 4'b0000, 4'b0000, "basic_fall");
        // phase now 0

        // 3: pulse sampled with sample_cnt=2 -> held exactly 9 cycles.
        while (ph != 2) step(1'b0, 4'b0000, 4'b0000, "align_min");
        step(1'b0, 4'b0010, 4'b0010, "min_rise");
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0000, 4'b0010, "min_hold");
        step(1'b0, 4'b0000, 4'b0000, "min_fall");
        // phase now 0

        // 4: retrigger 6 cycles after the first pulse; no low gap.
        step(1'b0, 4'b0100, 4'b0100, "retrig_rise");
        for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 4'b0100, "retrig_hold1");
        step(1'b0, 4'b0100, 4'b0100, "retrig_again");
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0000, 4'b0100, "retrig_hold2");
        step(1'b0, 4'b0000, 4'b0000, "retrig_fall");
        // phase now 0

        // 5: two channels held high 10 cycles, fall together 10 cycles after drop.
        for (int k = 0; k < 10; k++) step(1'b0, 4'b1010, 4'b1010, "held_high");
        for (int k = 0; k < 9; k++) step(1'b0, 4'b0000, 4'b1010, "held_tail");
        step(1'b0, 4'b0000, 4'b0000, "held_fall");
        // phase now 0

        // 6: reset mid-stretch, no resume, then a fresh pulse behaves normally.
        step(1'b0, 4'b0001, 4'b0001, "midrst_rise");
        for (int k = 0; k < 4; k++) step(1'b0, 4'b0000, 4'b0001, "midrst_hold");
        step(1'b1, 4'b0000, 4'b0000, "midrst_clear");
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 4'b0000, "midrst_noresume");
        chk_tick(1'b1, "tick_after_midrst");
        step(1'b0, 4'b0001, 4'b0001, "again_rise");
        for (int k = 0; k < 11; k++) step(1'b0, 4'b0000, 4'b0001, "again_hold");
        step(1'b0, 4'b0000, 4'b0000, "again_fall");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
